// File: rtl/csa_pkg.sv
// Shared defaults and helpers for the pipelined carry-select adder.
package csa_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_BLK   = 4;

    // Number of carry-select blocks, which is also the pipeline depth.
    function automatic int calc_nblk(input int width, input int blk);
        return width / blk;
    endfunction

endpackage

// File: rtl/csa_block.sv
// One carry-select block: two BLK-bit ripple adders (carry-in 0 and 1) and
// the mux that picks between them once the real carry is known.
module csa_block
    import csa_pkg::*;
#(
    parameter int BLK = DEFAULT_BLK
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           sel,
    output logic [BLK-1:0] sum,
    output logic           cout
);

    logic [BLK-1:0] sum0;
    logic [BLK-1:0] sum1;
    logic           cout0;
    logic           cout1;

    always_comb begin
        logic c0;
        logic c1;
        c0   = 1'b0;
        c1   = 1'b1;
        sum0 = '0;
        sum1 = '0;
        for (int i = 0; i < BLK; i++) begin
            sum0[i] = a[i] ^ b[i] ^ c0;
            sum1[i] = a[i] ^ b[i] ^ c1;
            c0      = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
            c1      = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
        end
        cout0 = c0;
        cout1 = c1;
    end

    assign sum  = sel ? sum1 : sum0;
    assign cout = sel ? cout1 : cout0;

endmodule

// File: rtl/csa_pipe.sv
// Pipelined adder/subtractor: stage k resolves result bits [k*BLK +: BLK],
// so the depth and latency both equal WIDTH/BLK.
module csa_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int BLK   = DEFAULT_BLK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = calc_nblk(WIDTH, BLK);

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Subtraction is a + ~b + 1, so the forced carry-in replaces cin.
    always_comb begin
        b_eff   = sub ? ~b : b;
        cin_eff = sub | cin;
    end

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        localparam int REM  = WIDTH - k * BLK;
        localparam int DONE = (k + 1) * BLK;

        logic [REM-1:0]  src_a;
        logic [REM-1:0]  src_b;
        logic            sel;
        logic            valid_d;
        logic            valid_q;
        logic            carry_d;
        logic            carry_q;
        logic            blk_cout;
        logic [BLK-1:0]  blk_sum;
        logic [DONE-1:0] sum_d;
        logic [DONE-1:0] sum_q;

        if (k == 0) begin : g_head
            always_comb begin
                src_a   = a;
                src_b   = b_eff;
                sel     = cin_eff;
                valid_d = in_valid;
            end
            always_comb sum_d = blk_sum;
        end else begin : g_body
            always_comb begin
                src_a   = g_stage[k-1].g_fwd.a_q;
                src_b   = g_stage[k-1].g_fwd.b_q;
                sel     = g_stage[k-1].carry_q;
                valid_d = g_stage[k-1].valid_q;
            end
            always_comb sum_d = {blk_sum, g_stage[k-1].sum_q};
        end

        csa_block #(.BLK(BLK)) u_blk (
            .a    (src_a[BLK-1:0]),
            .b    (src_b[BLK-1:0]),
            .sel  (sel),
            .sum  (blk_sum),
            .cout (blk_cout)
        );

        always_comb carry_d = blk_cout;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (en) begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        // Only the not-yet-added operand bits travel on to later stages.
        if (k < NBLK - 1) begin : g_fwd
            logic [REM-BLK-1:0] a_d;
            logic [REM-BLK-1:0] b_d;
            logic [REM-BLK-1:0] a_q;
            logic [REM-BLK-1:0] b_q;

            always_comb begin
                a_d = src_a[REM-1:BLK];
                b_d = src_b[REM-1:BLK];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : g_tail
            logic ovf_d;
            logic ovf_q;

            always_comb ovf_d = (src_a[BLK-1] == src_b[BLK-1]) &&
                                (blk_sum[BLK-1] != src_a[BLK-1]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[NBLK-1].valid_q;
    assign sum       = g_stage[NBLK-1].sum_q;
    assign cout      = g_stage[NBLK-1].carry_q;
    assign ovf       = g_stage[NBLK-1].g_tail.ovf_q;

endmodule

// File: tb/tb_csa_pipe.sv
// Testbench for csa_pipe: directed corner cases on the 16/4 build, then random
// traffic with backpressure on the 8/2, 16/4 and 32/8 builds against a model.
module tb_csa_pipe;

    localparam int LAT = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        sub;
    logic [31:0] a_bus;
    logic [31:0] b_bus;

    logic        rdy8, rdy16, rdy32;
    logic        ov8, ov16, ov32;
    logic        co8, co16, co32;
    logic        of8, of16, of32;
    logic [7:0]  sum8;
    logic [15:0] sum16;
    logic [31:0] sum32;

    int checks   = 0;
    int failures = 0;

    op_t exp_q[$];

    always #5 clk = ~clk;

    csa_pipe #(.WIDTH(8), .BLK(2)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .cin(cin), .sub(sub),
        .out_valid(ov8), .out_ready(out_ready), .sum(sum8), .cout(co8), .ovf(of8)
    );

    csa_pipe #(.WIDTH(16), .BLK(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
        .a(a_bus[15:0]), .b(b_bus[15:0]), .cin(cin), .sub(sub),
        .out_valid(ov16), .out_ready(out_ready), .sum(sum16), .cout(co16), .ovf(of16)
    );

    csa_pipe #(.WIDTH(32), .BLK(8)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .a(a_bus), .b(b_bus), .cin(cin), .sub(sub),
        .out_valid(ov32), .out_ready(out_ready), .sum(sum32), .cout(co32), .ovf(of32)
    );

    // Reference: plain integer arithmetic on the low w bits; returns {ovf, cout, sum}.
    function automatic logic [33:0] ref_result(input int w, input op_t op);
        longint unsigned mask, am, bm, full, s;
        logic o;
        mask = (64'd1 << w) - 64'd1;
        am   = {32'b0, op.a} & mask;
        bm   = op.sub ? (~{32'b0, op.b}) & mask : {32'b0, op.b} & mask;
        full = am + bm + (op.sub ? 64'd1 : {63'b0, op.cin});
        s    = full & mask;
        o    = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
        return {o, full[w], s[31:0]};
    endfunction

    function automatic logic [33:0] dut_result(input int idx);
        case (idx)
            0:       return {of8, co8, 24'b0, sum8};
            1:       return {of16, co16, 16'b0, sum16};
            default: return {of32, co32, sum32};
        endcase
    endfunction

    function automatic op_t rand_op();
        op_t op;
        op.a   = $urandom;
        op.b   = $urandom;
        op.cin = 1'($urandom_range(0, 1));
        op.sub = 1'($urandom_range(0, 1));
        return op;
    endfunction

    task automatic drive_op(input op_t op);
        a_bus = op.a;
        b_bus = op.b;
        cin   = op.cin;
        sub   = op.sub;
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_bus = '0; b_bus = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (ov16 !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", ov16); end
        if (sum16 !== 16'h0) begin failures++; $display("[TB] FAIL reset_sum: got %h expected 0000", sum16); end
        if (co16 !== 1'b0) begin failures++; $display("[TB] FAIL reset_cout: got %b expected 0", co16); end
        if (of16 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf: got %b expected 0", of16); end
        if (rdy16 !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", rdy16); end
        // Release between edges with an operand waiting: the very next edge must take it.
        @(posedge clk);
        #2;
        rst_n = 1'b1; in_valid = 1'b1; a_bus = 32'h1234; b_bus = 32'h1111;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (ov16 !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        checks += 2;
        if (lat != LAT) begin failures++; $display("[TB] FAIL first_accept_latency: got %0d expected %0d", lat, LAT); end
        if (sum16 !== 16'h2345) begin failures++; $display("[TB] FAIL first_accept_sum: got %h expected 2345", sum16); end
    endtask

    task automatic test_corners();
        logic [15:0] ta [6] = '{16'hFFFF, 16'h0005, 16'h8000, 16'h7FFF, 16'h0003, 16'h8000};
        logic [15:0] tb [6] = '{16'h0001, 16'h0007, 16'h0001, 16'h0000, 16'h0003, 16'h8000};
        logic        tc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        ts [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] es [6] = '{16'h0000, 16'hFFFE, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000};
        logic        ec [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        eo [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1; out_ready = 1'b1;
            a_bus = {16'h0, ta[i]}; b_bus = {16'h0, tb[i]}; cin = tc[i]; sub = ts[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 0;
            while (ov16 !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
            checks += 4;
            if (lat != LAT) begin failures++; $display("[TB] FAIL corner%0d_latency: got %0d expected %0d", i, lat, LAT); end
            if (sum16 !== es[i]) begin failures++; $display("[TB] FAIL corner%0d_sum: got %h expected %h", i, sum16, es[i]); end
            if (co16 !== ec[i]) begin failures++; $display("[TB] FAIL corner%0d_cout: got %b expected %b", i, co16, ec[i]); end
            if (of16 !== eo[i]) begin failures++; $display("[TB] FAIL corner%0d_ovf: got %b expected %b", i, of16, eo[i]); end
        end
    endtask

    task automatic test_back_to_back();
        op_t         vec [8];
        logic [33:0] exp_r;
        int          sent = 0;
        int          got  = 0;
        bit          stall;
        for (int i = 0; i < 8; i++) vec[i] = rand_op();
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(posedge clk);
            #1;
            stall     = (cyc >= 5 && cyc <= 7);
            out_ready = !stall;
            in_valid  = (sent < 8);
            if (sent < 8) drive_op(vec[sent]);
            @(negedge clk);
            if (stall) begin
                checks += 2;
                if (ov16 !== 1'b1) begin failures++; $display("[TB] FAIL stall_out_valid: got %b expected 1", ov16); end
                if (rdy16 !== 1'b0) begin failures++; $display("[TB] FAIL stall_in_ready: got %b expected 0", rdy16); end
            end
            if (ov16 === 1'b1) begin
                checks++;
                if (got >= 8) begin
                    failures++; $display("[TB] FAIL b2b_extra_output: got sum %h expected none", sum16);
                end else begin
                    exp_r = ref_result(16, vec[got]);
                    if (dut_result(1) !== exp_r) begin
                        failures++; $display("[TB] FAIL b2b_result%0d: got %h expected %h", got, dut_result(1), exp_r);
                    end
                end
                if (out_ready) got++;
            end
            if (in_valid && rdy16 === 1'b1) sent++;
        end
        checks++;
        if (got != 8) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 8", got); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (ov16 !== 1'b0) begin failures++; $display("[TB] FAIL b2b_duplicate: got out_valid %b expected 0", ov16); end
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a_bus = 32'h0101 * (i + 1); b_bus = 32'h0010; cin = 1'b0; sub = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ov16 !== 1'b1) begin failures++; $display("[TB] FAIL midflight_full: got out_valid %b expected 1", ov16); end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (ov16 !== 1'b0) begin failures++; $display("[TB] FAIL async_clear_valid: got %b expected 0", ov16); end
        if (sum16 !== 16'h0) begin failures++; $display("[TB] FAIL async_clear_sum: got %h expected 0000", sum16); end
        if (rdy16 !== 1'b1) begin failures++; $display("[TB] FAIL async_in_ready: got %b expected 1", rdy16); end
        @(posedge clk);
        #2;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (ov16 !== 1'b0) begin failures++; $display("[TB] FAIL stale_after_reset: got out_valid %b expected 0", ov16); end
        end
    endtask

    task automatic test_random();
        op_t         op;
        op_t         front;
        logic [33:0] exp_r;
        int          widths [3] = '{8, 16, 32};
        int          accepted = 0;
        int          cyc = 0;
        exp_q.delete();
        while (cyc < 20000 && (accepted < 3334 || exp_q.size() > 0)) begin
            @(posedge clk);
            #1;
            op        = rand_op();
            drive_op(op);
            in_valid  = (accepted < 3334) && ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            checks += 3;
            if (rdy16 !== (!ov16 || out_ready)) begin
                failures++; $display("[TB] FAIL rand_in_ready: got %b expected %b", rdy16, !ov16 || out_ready);
            end
            if ({ov8, ov32} !== {ov16, ov16}) begin
                failures++; $display("[TB] FAIL rand_valid_align: got %b%b expected %b%b", ov8, ov32, ov16, ov16);
            end
            if ({rdy8, rdy32} !== {rdy16, rdy16}) begin
                failures++; $display("[TB] FAIL rand_ready_align: got %b%b expected %b%b", rdy8, rdy32, rdy16, rdy16);
            end
            if (ov16 === 1'b1 && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL rand_spurious: got sum %h expected no output", sum16);
                end else begin
                    front = exp_q.pop_front();
                    for (int i = 0; i < 3; i++) begin
                        exp_r = ref_result(widths[i], front);
                        checks++;
                        if (dut_result(i) !== exp_r) begin
                            failures++;
                            $display("[TB] FAIL rand_w%0d: got %h expected %h", widths[i], dut_result(i), exp_r);
                        end
                    end
                end
            end
            if (in_valid && rdy16 === 1'b1) begin
                exp_q.push_back(op);
                accepted++;
            end
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0 || accepted < 3334) begin
            failures++; $display("[TB] FAIL rand_drain: got %0d pending, %0d accepted expected 0 pending, 3334 accepted", exp_q.size(), accepted);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_corners();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csa_pipe.md
CSA_PIPE -- requirements
Module: csa_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits.
REQ-002 SHALL have parameter BLK, default 4: carry-select block width in bits; WIDTH % BLK == 0, BLK >= 2.
REQ-003 SHALL define derived constant NBLK = WIDTH/BLK, which is both the pipeline depth and the latency.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  operands present this cycle.
REQ-007 in_ready  out  1  block can accept operands this cycle.
REQ-008 a  in  WIDTH  operand A, unsigned/two's-complement.
REQ-009 b  in  WIDTH  operand B.
REQ-010 cin  in  1  carry-in; used in add mode only.
REQ-011 sub  in  1  0 = add, 1 = subtract.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 sum  out  WIDTH  result.
REQ-015 cout  out  1  carry out of the MSB; in subtract mode, 1 = no borrow.
REQ-016 ovf  out  1  two's-complement signed overflow.

Function
REQ-017 Add mode: {cout,sum} SHALL equal a + b + cin, modulo 2^(WIDTH+1).
REQ-018 Subtract mode: {cout,sum} SHALL equal a + ~b + 1; cin is ignored.
REQ-019 ovf SHALL be 1 iff the MSBs of both effective operands are equal and differ from the sum MSB.
REQ-020 Stage k (0..NBLK-1) SHALL compute bits [k*BLK +: BLK] as two precomputed results (carry 0 and carry 1) and select between them with the carry registered from stage k-1; stage 0 selects with the effective carry-in.
REQ-021 Operands for later blocks and completed lower sum bits SHALL be carried forward in pipeline registers.
REQ-022 Latency: a transfer accepted at edge N (in_valid && in_ready) SHALL appear on out_valid/sum after edge N+NBLK-1, provided there is no stall.
REQ-023 Global advance enable SHALL be en = !out_valid || out_ready.
REQ-024 in_ready SHALL equal en.
REQ-025 When en = 0, every stage register including valid bits SHALL hold.
REQ-026 Each stage SHALL carry a valid bit; bubbles propagate as valid = 0 and are not compressed.
REQ-027 Throughput: one result per cycle with out_ready held at 1.
REQ-028 While out_valid && !out_ready, sum/cout/ovf SHALL remain stable.
REQ-029 in_valid = 0 while en = 1 SHALL inject a bubble.
REQ-030 Data regs of invalid stages are don't-care, but out outputs SHALL never be X after reset.
REQ-031 Wrap-around: 0xFFFF + 0x0001 (WIDTH=16) SHALL give sum = 0, cout = 1; no saturation.

Reset
REQ-032 When rst_n = 0, all valid bits SHALL clear immediately, without waiting for a clock edge.
REQ-033 When rst_n = 0, out_valid, sum, cout and ovf SHALL be 0.
REQ-034 Reset mid-operation SHALL discard all in-flight results, with no output after release.
REQ-035 in_ready SHALL be 1 during and after reset.
REQ-036 The first accept SHALL be possible on the first rising edge after rst_n rises.

Structure
REQ-037 Package csa_pkg SHALL hold the default WIDTH/BLK constants and a function computing NBLK.
REQ-038 One sub-module, csa_block, SHALL hold the combinational BLK-bit dual ripple adder (carry-0/carry-1 sums and carries) plus the carry-select mux; it is instantiated NBLK times via generate.
REQ-039 Pipeline registers SHALL reside only in csa_pipe.

Verification (WIDTH=16, BLK=4, latency 4)
REQ-040 Add a=0xFFFF, b=0x0001, cin=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
REQ-041 Sub a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0; sub a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-042 Add a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1 (carry rippling through all blocks).
REQ-043 Stream 8 back-to-back vectors, then hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 while stalled, outputs stable, all 8 results in order, none lost or duplicated.
REQ-044 Assert rst_n=0 for 1 cycle with 3 results in flight -> out_valid=0 immediately and no stale result after release.
REQ-045 Random 10k vectors across parameter sets (8,2), (16,4) and (32,8) with random bubbles/backpressure, checked against a reference-model queue.
